// File: rtl/hpi_pkg.sv
// Shared HPI definitions: host register-select encodings and target FSM states.
package hpi_pkg;
  typedef enum logic [1:0] {
    HPI_DATA    = 2'd0,
    HPI_MAILBOX = 2'd1,
    HPI_ADDRESS = 2'd2,
    HPI_STATUS  = 2'd3
  } hpi_reg_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } hpi_state_e;
endpackage

// File: rtl/hpi_io_intf.sv
// Bundle of the HPI host-side pins, for blocks that pass the bus around as one object.
interface hpi_io_intf;
  import hpi_pkg::*;
  wire [15:0] data;
  hpi_reg_e   addr;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       rst_n;
  logic       intr;

  modport target (inout data, input addr, input cs_n, input rd_n, input wr_n,
                  input rst_n, output intr);
  modport host   (inout data, output addr, output cs_n, output rd_n, output wr_n,
                  output rst_n, input intr);
endinterface

// File: rtl/hpi_target_ram.sv
// Single-clock target memory: one write port, one registered read port that holds when idle.
module hpi_target_ram #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);
  logic [15:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/hpi_target.sv
// HPI target: host register file (DATA/MAILBOX/ADDRESS/STATUS) over a shared RAM,
// with a local keycode write port and a pair of mailboxes.
module hpi_target import hpi_pkg::*; #(
  parameter int          MEM_WORDS = 256,
  parameter logic [15:0] KEY_WORD  = 16'h051C
) (
  input  logic        Clk,
  input  logic        Reset_n,
  inout  wire  [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
  output logic        OTG_INT,
  input  logic        key_valid,
  input  logic [15:0] key_code,
  input  logic        mbx_out_valid,
  input  logic [15:0] mbx_out_data,
  output logic        mbx_in_valid,
  output logic [15:0] mbx_in_data
);
  localparam int            AW      = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] KEY_IDX = KEY_WORD[AW:1];

  hpi_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d, rd_q, rd_d;
  logic [15:0] mbx_out_q, mbx_out_d, mbx_in_data_q, mbx_in_data_d;
  logic [15:0] key_pdata_q, key_pdata_d;
  logic        rd_mem_q, rd_mem_d, out_full_q, out_full_d, in_seen_q, in_seen_d;
  logic        mbx_in_vld_q, mbx_in_vld_d, block_q, block_d, key_pend_q, key_pend_d;

  hpi_reg_e    sel;
  logic        strobe_idle, rd_go, wr_go, mem_re, host_we, key_any, mem_we;
  logic [15:0] key_val, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_waddr;

  assign sel         = hpi_reg_e'(OTG_ADDR);
  assign strobe_idle = OTG_CS_N | (OTG_RD_N & OTG_WR_N);
  // block_q keeps an access cut short by reset from restarting until the host lets go
  assign rd_go = (state_q == ST_IDLE) & ~block_q & ~OTG_CS_N & ~OTG_RD_N &  OTG_WR_N;
  assign wr_go = (state_q == ST_IDLE) & ~block_q & ~OTG_CS_N &  OTG_RD_N & ~OTG_WR_N;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rd_d          = rd_q;
    rd_mem_d      = rd_mem_q;
    mbx_out_d     = mbx_out_q;
    out_full_d    = out_full_q;
    in_seen_d     = in_seen_q;
    mbx_in_vld_d  = 1'b0;
    mbx_in_data_d = mbx_in_data_q;
    block_d       = block_q & ~strobe_idle;
    mem_re        = 1'b0;
    host_we       = 1'b0;

    unique case (state_q)
      ST_IDLE: if (rd_go) state_d = ST_RD; else if (wr_go) state_d = ST_WR;
      ST_RD:   if (OTG_CS_N | OTG_RD_N) state_d = ST_IDLE;
      ST_WR:   if (OTG_CS_N | OTG_WR_N) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (rd_go) begin
      rd_mem_d = (sel == HPI_DATA);
      case (sel)
        HPI_DATA:    begin mem_re = 1'b1; addr_d = addr_q + 16'd2; end
        HPI_MAILBOX: begin rd_d = mbx_out_q; out_full_d = 1'b0; in_seen_d = 1'b0; end
        HPI_ADDRESS: rd_d = addr_q;
        default:     rd_d = {14'b0, in_seen_q, out_full_q};
      endcase
    end

    if (wr_go) begin
      case (sel)
        HPI_DATA:    begin host_we = 1'b1; addr_d = addr_q + 16'd2; end
        HPI_MAILBOX: begin mbx_in_vld_d = 1'b1; mbx_in_data_d = OTG_DATA; in_seen_d = 1'b1; end
        HPI_ADDRESS: addr_d = {OTG_DATA[15:1], 1'b0};
        default: ;
      endcase
    end

    // a local push lands after a concurrent host read, so full stays set
    if (mbx_out_valid) begin
      mbx_out_d  = mbx_out_data;
      out_full_d = 1'b1;
    end

    if (!OTG_RST_N) begin
      state_d       = ST_IDLE;
      addr_d        = 16'h0000;
      mbx_out_d     = 16'h0000;
      out_full_d    = 1'b0;
      in_seen_d     = 1'b0;
      mbx_in_vld_d  = 1'b0;
      mbx_in_data_d = 16'h0000;
      block_d       = 1'b1;
      mem_re        = 1'b0;
      host_we       = 1'b0;
    end
  end

  // Host owns the write port; a key write losing to a host write elsewhere retires next cycle.
  assign key_any     = key_valid | key_pend_q;
  assign key_val     = key_valid ? key_code : key_pdata_q;
  assign key_pend_d  = host_we & key_any & (addr_q[AW:1] != KEY_IDX);
  assign key_pdata_d = key_val;
  assign mem_we      = host_we | key_any;
  assign mem_waddr   = host_we ? addr_q[AW:1] : KEY_IDX;
  assign mem_wdata   = host_we ? OTG_DATA : key_val;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= 16'h0000;
      rd_q          <= 16'h0000;
      rd_mem_q      <= 1'b0;
      mbx_out_q     <= 16'h0000;
      out_full_q    <= 1'b0;
      in_seen_q     <= 1'b0;
      mbx_in_vld_q  <= 1'b0;
      mbx_in_data_q <= 16'h0000;
      block_q       <= 1'b1;
      key_pend_q    <= 1'b0;
      key_pdata_q   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rd_q          <= rd_d;
      rd_mem_q      <= rd_mem_d;
      mbx_out_q     <= mbx_out_d;
      out_full_q    <= out_full_d;
      in_seen_q     <= in_seen_d;
      mbx_in_vld_q  <= mbx_in_vld_d;
      mbx_in_data_q <= mbx_in_data_d;
      block_q       <= block_d;
      key_pend_q    <= key_pend_d;
      key_pdata_q   <= key_pdata_d;
    end
  end

  hpi_target_ram #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
    .clk_i   (Clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (addr_q[AW:1]),
    .rdata_o (mem_rdata)
  );

  assign OTG_DATA     = (state_q == ST_RD) ? (rd_mem_q ? mem_rdata : rd_q) : 16'hzzzz;
  assign OTG_INT      = out_full_q;
  assign mbx_in_valid = mbx_in_vld_q;
  assign mbx_in_data  = mbx_in_data_q;
endmodule

// File: tb/tb_hpi_target.sv
// Directed bench for hpi_target: register vector table plus mailbox, key, and reset sequences.
module tb_hpi_target;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  wire  [15:0] OTG_DATA;
  logic [1:0]  OTG_ADDR = 2'd0;
  logic        OTG_CS_N = 1'b1, OTG_RD_N = 1'b1, OTG_WR_N = 1'b1, OTG_RST_N = 1'b1;
  logic        OTG_INT;
  logic        key_valid = 1'b0, mbx_out_valid = 1'b0, mbx_in_valid;
  logic [15:0] key_code = 16'h0, mbx_out_data = 16'h0, mbx_in_data;
  logic        drv_en = 1'b0;
  logic [15:0] drv_val = 16'h0;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [15:0] pulse_dat = 16'h0;

  localparam logic [1:0] S_DAT = 2'd0, S_MBX = 2'd1, S_ADR = 2'd2, S_STS = 2'd3;

  // released bus floats to all-ones so high-impedance is observable
  pullup (OTG_DATA);
  assign OTG_DATA = drv_en ? drv_val : 16'hzzzz;

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (mbx_in_valid) begin
    pulse_cnt <= pulse_cnt + 1;
    pulse_dat <= mbx_in_data;
  end

  hpi_target #(.MEM_WORDS(256), .KEY_WORD(16'h051C)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .OTG_DATA(OTG_DATA), .OTG_ADDR(OTG_ADDR),
    .OTG_CS_N(OTG_CS_N), .OTG_RD_N(OTG_RD_N), .OTG_WR_N(OTG_WR_N), .OTG_RST_N(OTG_RST_N),
    .OTG_INT(OTG_INT), .key_valid(key_valid), .key_code(key_code),
    .mbx_out_valid(mbx_out_valid), .mbx_out_data(mbx_out_data),
    .mbx_in_valid(mbx_in_valid), .mbx_in_data(mbx_in_data)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic hwrite(input logic [1:0] sel, input logic [15:0] d, input int len = 1,
                        input logic kv = 1'b0, input logic [15:0] kd = 16'h0);
    @(negedge Clk);
    OTG_ADDR = sel; drv_val = d; drv_en = 1'b1; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    key_valid = kv; key_code = kd;
    @(negedge Clk);
    key_valid = 1'b0;
    repeat (len - 1) @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1; drv_en = 1'b0;
  endtask

  task automatic hread(input logic [1:0] sel, output logic [15:0] d,
                       input logic pv = 1'b0, input logic [15:0] pd = 16'h0);
    @(negedge Clk);
    OTG_ADDR = sel; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    mbx_out_valid = pv; mbx_out_data = pd;
    @(negedge Clk);
    mbx_out_valid = 1'b0;
    d = OTG_DATA;
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
  endtask

  typedef struct packed {
    logic        wr;
    logic [1:0]  sel;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [15:0] d;
    int p0;

    tbl[0]  = '{1'b1, S_ADR, 16'h1000, 16'h0000};
    tbl[1]  = '{1'b1, S_DAT, 16'hAAAA, 16'h0000};
    tbl[2]  = '{1'b1, S_DAT, 16'h5555, 16'h0000};
    tbl[3]  = '{1'b1, S_ADR, 16'h1000, 16'h0000};
    tbl[4]  = '{1'b0, S_DAT, 16'h0000, 16'hAAAA};
    tbl[5]  = '{1'b0, S_DAT, 16'h0000, 16'h5555};
    tbl[6]  = '{1'b0, S_ADR, 16'h0000, 16'h1004};
    tbl[7]  = '{1'b1, S_ADR, 16'h1003, 16'h0000};
    tbl[8]  = '{1'b0, S_ADR, 16'h0000, 16'h1002};
    tbl[9]  = '{1'b0, S_STS, 16'h0000, 16'h0000};
    tbl[10] = '{1'b1, S_STS, 16'hFFFF, 16'h0000};
    tbl[11] = '{1'b0, S_STS, 16'h0000, 16'h0000};
    tbl[12] = '{1'b0, S_ADR, 16'h0000, 16'h1002};
    tbl[13] = '{1'b1, S_ADR, 16'hFFFE, 16'h0000};
    tbl[14] = '{1'b1, S_DAT, 16'h1357, 16'h0000};
    tbl[15] = '{1'b0, S_ADR, 16'h0000, 16'h0000};
    tbl[16] = '{1'b1, S_DAT, 16'hC0DE, 16'h0000};
    tbl[17] = '{1'b1, S_ADR, 16'h0200, 16'h0000};
    tbl[18] = '{1'b0, S_DAT, 16'h0000, 16'hC0DE};
    tbl[19] = '{1'b1, S_ADR, 16'h01FE, 16'h0000};
    tbl[20] = '{1'b0, S_DAT, 16'h0000, 16'h1357};

    // reset state
    #3;
    check("rst_bus_hiz", OTG_DATA, 16'hFFFF);
    check("rst_int", {15'b0, OTG_INT}, 16'h0);
    check("rst_mbx_in_valid", {15'b0, mbx_in_valid}, 16'h0);
    check("rst_mbx_in_data", mbx_in_data, 16'h0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    hread(S_ADR, d); check("rst_addr", d, 16'h0000);
    hread(S_STS, d); check("rst_status", d, 16'h0000);

    for (int i = 0; i < 21; i++) begin
      if (tbl[i].wr) hwrite(tbl[i].sel, tbl[i].d);
      else begin
        hread(tbl[i].sel, d);
        check($sformatf("vec[%0d]", i), d, tbl[i].exp);
      end
    end

    // outbound mailbox
    @(negedge Clk); mbx_out_valid = 1'b1; mbx_out_data = 16'hBEEF;
    @(negedge Clk); mbx_out_valid = 1'b0;
    check("obx_int_set", {15'b0, OTG_INT}, 16'h1);
    hread(S_STS, d); check("obx_status_full", d, 16'h0001);
    hread(S_MBX, d); check("obx_read", d, 16'hBEEF);
    check("obx_int_clr", {15'b0, OTG_INT}, 16'h0);
    hread(S_STS, d); check("obx_status_clr", d, 16'h0000);

    // push racing a MAILBOX read keeps full set and replaces the word
    @(negedge Clk); mbx_out_valid = 1'b1; mbx_out_data = 16'hAAAA;
    @(negedge Clk); mbx_out_valid = 1'b0;
    hread(S_MBX, d, 1'b1, 16'h2222); check("obx_race_read", d, 16'hAAAA);
    check("obx_race_int", {15'b0, OTG_INT}, 16'h1);
    hread(S_MBX, d); check("obx_race_new", d, 16'h2222);
    check("obx_race_int_clr", {15'b0, OTG_INT}, 16'h0);

    // inbound mailbox with a long strobe
    p0 = pulse_cnt;
    hwrite(S_MBX, 16'h1234, 4);
    repeat (3) @(negedge Clk);
    check("ibx_pulse_count", 16'(pulse_cnt - p0), 16'd1);
    check("ibx_pulse_data", pulse_dat, 16'h1234);
    hread(S_STS, d); check("ibx_status", d, 16'h0002);
    hread(S_MBX, d);
    hread(S_STS, d); check("ibx_status_clr", d, 16'h0000);

    // local keycode port
    @(negedge Clk); key_valid = 1'b1; key_code = 16'h0004;
    @(negedge Clk); key_valid = 1'b0;
    hwrite(S_ADR, 16'h051C);
    hread(S_DAT, d); check("key_write", d, 16'h0004);
    hwrite(S_ADR, 16'h051C);
    hwrite(S_DAT, 16'h0007, 1, 1'b1, 16'h0004);
    hwrite(S_ADR, 16'h051C);
    hread(S_DAT, d); check("key_host_wins", d, 16'h0007);
    hwrite(S_ADR, 16'h0100);
    hwrite(S_DAT, 16'h00AB, 1, 1'b1, 16'h0099);
    hwrite(S_ADR, 16'h051C);
    hread(S_DAT, d); check("key_other_word", d, 16'h0099);
    hwrite(S_ADR, 16'h0100);
    hread(S_DAT, d); check("host_other_word", d, 16'h00AB);

    // RD and WR both low: no effect
    hwrite(S_ADR, 16'h0AB0);
    @(negedge Clk);
    OTG_ADDR = S_ADR; drv_val = 16'h0F0E; drv_en = 1'b1;
    OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; OTG_WR_N = 1'b0;
    repeat (2) @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_WR_N = 1'b1; drv_en = 1'b0;
    hread(S_ADR, d); check("proto_err", d, 16'h0AB0);

    // host soft reset clears registers, keeps memory
    @(negedge Clk); mbx_out_valid = 1'b1; mbx_out_data = 16'h7777;
    @(negedge Clk); mbx_out_valid = 1'b0; OTG_RST_N = 1'b0;
    @(negedge Clk); OTG_RST_N = 1'b1;
    check("soft_rst_int", {15'b0, OTG_INT}, 16'h0);
    hread(S_ADR, d); check("soft_rst_addr", d, 16'h0000);
    hread(S_DAT, d); check("soft_rst_mem_kept", d, 16'hC0DE);

    // hard reset in the middle of a read
    hwrite(S_ADR, 16'h0040);
    @(negedge Clk); OTG_ADDR = S_ADR; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    @(negedge Clk); check("mid_rd_drive", OTG_DATA, 16'h0040);
    #2 Reset_n = 1'b0;
    #1 check("mid_rd_hiz", OTG_DATA, 16'hFFFF);
    @(negedge Clk); Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("post_rst_no_access", OTG_DATA, 16'hFFFF);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
    hread(S_ADR, d); check("post_rst_addr", d, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hpi_target.md
HPI_TARGET -- requirements
Module: hpi_target

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning depth of 16-bit target memory, power of two, 16..4096.
REQ-002 SHALL have parameter KEY_WORD, default 16'h051C, meaning byte address where the local keycode port writes.
REQ-003 SHALL have port Clk  in  1  sole clock; all OTG_* inputs are synchronous to it.
REQ-004 SHALL have port Reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port OTG_DATA  inout  16  HPI data bus.
REQ-006 SHALL have port OTG_ADDR  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
REQ-007 SHALL have port OTG_CS_N  in  1  chip select, active-low.
REQ-008 SHALL have port OTG_RD_N  in  1  read strobe, active-low.
REQ-009 SHALL have port OTG_WR_N  in  1  write strobe, active-low.
REQ-010 SHALL have port OTG_RST_N  in  1  host soft reset, active-low.
REQ-011 SHALL have port OTG_INT  out  1  high while the outbound mailbox is full.
REQ-012 SHALL have port key_valid / key_code  in  1 / 16  local one-cycle keycode write.
REQ-013 SHALL have port mbx_out_valid / mbx_out_data  in  1 / 16  local push to the outbound mailbox.
REQ-014 SHALL have port mbx_in_valid / mbx_in_data  out  1 / 16  one-cycle pulse carrying a host mailbox write.

Function
REQ-015 SHALL run FSM IDLE, RD, WR; IDLE->RD when CS_N=0 and RD_N=0; IDLE->WR when CS_N=0 and WR_N=0; RD/WR->IDLE when CS_N=1 or the strobe deasserts.
REQ-016 SHALL treat RD_N and WR_N both low as a protocol error: stay in IDLE, no side effects.
REQ-017 SHALL perform every access side effect exactly once, on the IDLE->RD/WR transition cycle, regardless of strobe length.
REQ-018 SHALL on RD entry load rd_reg from the selected register and drive OTG_DATA=rd_reg from the next cycle while in RD; read latency is 1 cycle.
REQ-019 SHALL hold OTG_DATA high-impedance in every state other than RD, including during reset.
REQ-020 SHALL hold the address register as a 16-bit byte address; the word index is addr[log2(MEM_WORDS):1], so memory aliases modulo MEM_WORDS.
REQ-021 SHALL on a DATA read or write use the current address, then post-increment it by 2, wrapping 16'hFFFE->16'h0000.
REQ-022 SHALL on an ADDRESS write load the address from OTG_DATA with bit 0 forced to 0; an ADDRESS read returns the current address.
REQ-023 SHALL on a MAILBOX write pulse mbx_in_valid for 1 cycle with mbx_in_data=OTG_DATA and set STATUS bit1.
REQ-024 SHALL on a MAILBOX read return the outbound mailbox word, then clear outbound-full (deasserting OTG_INT next cycle) and clear STATUS bit1.
REQ-025 SHALL on a STATUS read return {14'b0, inbound_seen, outbound_full}; STATUS writes are ignored.
REQ-026 SHALL on mbx_out_valid latch mbx_out_data and set outbound_full; a push while full overwrites; a push coinciding with a MAILBOX read wins (full stays 1).
REQ-027 SHALL on key_valid write key_code to the word at KEY_WORD; a host DATA write to the same word in the same cycle wins.
REQ-028 SHALL treat OTG_RST_N=0 as a synchronous clear of address, mailboxes, status and FSM, but not of memory contents.

Reset
REQ-029 SHALL on Reset_n=0 asynchronously set FSM=IDLE, address=0, rd_reg=0, outbound_full=0, inbound_seen=0, OTG_INT=0, mbx_in_valid=0, mbx_in_data=0, with OTG_DATA released.
REQ-030 SHALL abandon an access in progress on reset and perform no side effect for it after reset releases until the strobes return high.
REQ-031 SHALL NOT reset memory contents.

Structure
REQ-032 SHALL take register-select encodings (HPI_DATA, HPI_MAILBOX, HPI_ADDRESS, HPI_STATUS) and the FSM state enum from the shared package hpi_pkg, which hpi_io_intf also imports.
REQ-033 SHALL place memory in one sub-module, hpi_target_ram: a single-clock RAM with one write port and one synchronous read port.

Verification
REQ-034 SHALL cover: ADDRESS write 16'h1000, DATA writes 16'hAAAA and 16'h5555, ADDRESS write 16'h1000, two DATA reads -> 16'hAAAA then 16'h5555, ADDRESS read -> 16'h1004.
REQ-035 SHALL cover: mbx_out push 16'hBEEF -> OTG_INT=1 and STATUS=16'h0001; MAILBOX read -> 16'hBEEF, then OTG_INT=0 and STATUS=16'h0000.
REQ-036 SHALL cover: MAILBOX write 16'h1234 with a 4-cycle WR strobe -> exactly one mbx_in_valid pulse carrying 16'h1234.
REQ-037 SHALL cover: ADDRESS write 16'hFFFE, DATA write -> ADDRESS read 16'h0000; with MEM_WORDS=256, the word at 16'h0000 equals the word at 16'h0200.
REQ-038 SHALL cover: key_valid=1 with key_code 16'h0004 and a same-cycle host DATA write 16'h0007 to KEY_WORD -> the word at KEY_WORD reads 16'h0007.
REQ-039 SHALL cover: Reset_n asserted mid-RD -> OTG_DATA high-impedance within the same cycle and address=0 after release.
